// File: rtl/pixel_mem_ctrl_pkg.sv
// Shared types and constants for the pixel memory sequencer.
package pixel_ctrl_pkg;
  localparam int IMG_DIM     = 32;
  localparam int KSIZE       = 3;
  localparam int PLANE_WORDS = 1024;
  localparam int LOAD_WORDS  = 3072;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SWEEP, ST_DRAIN} ctrl_state_e;

  typedef struct packed {
    logic [47:0] data;
    logic [3:0]  idx;
    logic        last;
  } tap_t;

  function automatic logic [3:0] tap_index(input logic [1:0] dy, input logic [1:0] dx);
    return {2'b0, dy} * 4'd3 + {2'b0, dx};
  endfunction
endpackage

// File: rtl/pixel_mem_ctrl_tap_skid_fifo.sv
// 2-entry skid FIFO of taps; head is presented combinationally from storage.
module tap_skid_fifo
  import pixel_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  tap_t       i_din,
  output tap_t       o_dout,
  output logic [1:0] o_count
);
  tap_t       r_mem [2];
  logic       r_wp, r_rp;
  logic [1:0] r_cnt;
  logic       w_push, w_pop;

  assign w_pop  = i_pop && (r_cnt != 2'd0);
  assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rp];
  assign o_count = r_cnt;
endmodule

// File: rtl/pixel_mem_ctrl.sv
// Load/sweep sequencer for the 32x32x3 pixel memory feeding 3x3 taps to the conv engine.
// Optional zero-padded full-frame sweep is enabled by defining PIXEL_ZERO_PAD_EN.
module pixel_mem_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_write_pixel_signal,
  output logic [15:0]       o_write_pixel_addr,
  output logic [DATA_W-1:0] o_write_pixel_data,
  output logic              o_read_pixel_signal,
  output logic [15:0]       o_read_pixel_addr,
  input  logic [47:0]       i_read_pixel_data,
  output logic              o_tap_valid,
  input  logic              i_tap_ready,
  output logic [47:0]       o_tap_data,
  output logic [3:0]        o_tap_idx,
  output logic              o_win_last,
  output logic              o_busy,
  output logic              o_done
);
  ctrl_state_e r_state;
  logic [11:0] r_ld_cnt;
  logic [4:0]  r_oy, r_ox;
  logic [1:0]  r_dy, r_dx;
  logic        r_done;

  logic        w_accept, w_pop, w_slot, w_inb, w_last_tap;
  logic [4:0]  w_row, w_col;
  logic [1:0]  w_cnt;
  tap_t        w_head, w_push_tap;

`ifdef PIXEL_ZERO_PAD_EN
  localparam logic [4:0] WIN_MAX = 5'(IMG_DIM - 1);
  // Positions are 1-based here so that coordinate -1 maps to 0 without going signed.
  logic [5:0] w_rpos, w_cpos;
  assign w_rpos = {1'b0, r_oy} + {4'b0, r_dy};
  assign w_cpos = {1'b0, r_ox} + {4'b0, r_dx};
  assign w_inb  = (w_rpos != 6'd0) && (w_rpos <= 6'(IMG_DIM)) &&
                  (w_cpos != 6'd0) && (w_cpos <= 6'(IMG_DIM));
  assign w_row  = 5'(w_rpos - 6'd1);
  assign w_col  = 5'(w_cpos - 6'd1);
`else
  localparam logic [4:0] WIN_MAX = 5'(IMG_DIM - KSIZE);
  assign w_inb = 1'b1;
  assign w_row = r_oy + {3'b0, r_dy};
  assign w_col = r_ox + {3'b0, r_dx};
`endif

  assign w_accept   = (r_state == ST_LOAD) && i_in_valid;
  assign w_pop      = i_tap_ready && (w_cnt != 2'd0);
  // Issue only if the buffer has room once this cycle's pop is accounted for.
  assign w_slot     = (r_state == ST_SWEEP) && ((w_cnt < 2'd2) || w_pop);
  assign w_last_tap = (r_oy == WIN_MAX) && (r_ox == WIN_MAX) && (r_dy == 2'd2) && (r_dx == 2'd2);

  assign w_push_tap.data = w_inb ? i_read_pixel_data : 48'd0;
  assign w_push_tap.idx  = tap_index(r_dy, r_dx);
  assign w_push_tap.last = w_last_tap;

  tap_skid_fifo u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_slot),
    .i_pop   (w_pop),
    .i_din   (w_push_tap),
    .o_dout  (w_head),
    .o_count (w_cnt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_ld_cnt <= '0;
      r_oy     <= '0;
      r_ox     <= '0;
      r_dy     <= '0;
      r_dx     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_state  <= ST_LOAD;
          r_ld_cnt <= '0;
        end
        ST_LOAD: if (w_accept) begin
          if (r_ld_cnt == 12'(LOAD_WORDS - 1)) begin
            r_ld_cnt <= '0;
            r_state  <= ST_SWEEP;
          end else begin
            r_ld_cnt <= r_ld_cnt + 12'd1;
          end
        end
        ST_SWEEP: if (w_slot) begin
          if (w_last_tap) r_state <= ST_DRAIN;
          // dx fastest, then dy, ox, oy; all wrap to zero after the final tap.
          if (r_dx != 2'd2) r_dx <= r_dx + 2'd1;
          else begin
            r_dx <= '0;
            if (r_dy != 2'd2) r_dy <= r_dy + 2'd1;
            else begin
              r_dy <= '0;
              if (r_ox != WIN_MAX) r_ox <= r_ox + 5'd1;
              else begin
                r_ox <= '0;
                r_oy <= (r_oy == WIN_MAX) ? 5'd0 : r_oy + 5'd1;
              end
            end
          end
        end
        ST_DRAIN: if (w_pop && w_head.last) begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_in_ready           = (r_state == ST_LOAD);
  assign o_write_pixel_signal = w_accept;
  assign o_write_pixel_addr   = w_accept ? {4'b0, r_ld_cnt} : 16'd0;
  assign o_write_pixel_data   = w_accept ? i_in_data : '0;
  assign o_read_pixel_signal  = w_slot && w_inb;
  assign o_read_pixel_addr    = (w_slot && w_inb) ? {6'b0, w_row, w_col} : 16'd0;
  assign o_tap_valid          = (w_cnt != 2'd0);
  assign o_tap_data           = w_head.data;
  assign o_tap_idx            = w_head.idx;
  assign o_win_last           = w_head.last && (w_cnt != 2'd0);
  assign o_busy               = (r_state == ST_LOAD) || (r_state == ST_SWEEP);
  assign o_done               = r_done;
endmodule

// File: tb/tb_pixel_mem_ctrl.sv
// Randomized bench for pixel_mem_ctrl with a window-level reference model and a memory model on ~clk.
module tb_pixel_mem_ctrl;
  typedef struct packed {logic [47:0] d; logic [3:0] i; logic l;} rec_t;
`ifdef PIXEL_ZERO_PAD_EN
  localparam int NW = 32, OFF = 1;
`else
  localparam int NW = 30, OFF = 0;
`endif

  logic clk = 0, rst = 1, start = 0, in_valid = 0, tap_ready = 0;
  logic [15:0] in_data = 0;
  logic [47:0] rd_data = 0;
  logic o_in_ready, o_write_pixel_signal, o_read_pixel_signal, o_tap_valid, o_win_last, o_busy, o_done;
  logic [15:0] o_write_pixel_addr, o_write_pixel_data, o_read_pixel_addr;
  logic [47:0] o_tap_data;
  logic [3:0]  o_tap_idx;

  always #5 clk = ~clk;

  pixel_mem_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid), .o_in_ready(o_in_ready),
    .i_in_data(in_data), .o_write_pixel_signal(o_write_pixel_signal),
    .o_write_pixel_addr(o_write_pixel_addr), .o_write_pixel_data(o_write_pixel_data),
    .o_read_pixel_signal(o_read_pixel_signal), .o_read_pixel_addr(o_read_pixel_addr),
    .i_read_pixel_data(rd_data), .o_tap_valid(o_tap_valid), .i_tap_ready(tap_ready),
    .o_tap_data(o_tap_data), .o_tap_idx(o_tap_idx), .o_win_last(o_win_last),
    .o_busy(o_busy), .o_done(o_done));

  logic [15:0] mem [3072];
  logic [15:0] img [3072];
  logic [31:0] wq[$];
  logic [15:0] rq[$], exp_r[$];
  rec_t tq[$], exp_t[$];
  rec_t cur, p_rec;
  logic p_stall = 0;
  int done_cnt, stall_bad, max_out, overlap;
  int checks = 0, errors = 0;

  // Memory model plus passive monitor, both on the falling edge.
  always @(negedge clk) begin
    if (o_write_pixel_signal) begin
      mem[int'(o_write_pixel_addr[11:0])] = o_write_pixel_data;
      wq.push_back({o_write_pixel_addr, o_write_pixel_data});
    end
    if (o_read_pixel_signal) begin
      rd_data = {mem[2048 + int'(o_read_pixel_addr[9:0])], mem[1024 + int'(o_read_pixel_addr[9:0])],
                 mem[int'(o_read_pixel_addr[9:0])]};
      rq.push_back(o_read_pixel_addr);
    end
    if (o_write_pixel_signal && o_read_pixel_signal) overlap++;
    cur = {o_tap_data, o_tap_idx, o_win_last};
    if (p_stall && (!o_tap_valid || cur != p_rec)) stall_bad++;
    p_stall = !rst && o_tap_valid && !tap_ready;
    p_rec = cur;
    if (o_tap_valid && tap_ready) tq.push_back(cur);
    if (o_done) done_cnt++;
    if (int'(rq.size()) - int'(tq.size()) > max_out) max_out = int'(rq.size()) - int'(tq.size());
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic clear_logs;
    wq.delete(); rq.delete(); tq.delete();
    done_cnt = 0; stall_bad = 0; max_out = 0; overlap = 0;
  endtask

  function automatic void build_exp;
    exp_t.delete(); exp_r.delete();
    for (int oy = 0; oy < NW; oy++)
      for (int ox = 0; ox < NW; ox++)
        for (int dy = 0; dy < 3; dy++)
          for (int dx = 0; dx < 3; dx++) begin
            int r = oy + dy - OFF;
            int c = ox + dx - OFF;
            rec_t e;
            e.d = 48'd0;
            if (r >= 0 && r < 32 && c >= 0 && c < 32) begin
              int a = r * 32 + c;
              exp_r.push_back(16'(a));
              e.d = {img[2048 + a], img[1024 + a], img[a]};
            end
            e.i = 4'(dy * 3 + dx);
            e.l = (oy == NW - 1) && (ox == NW - 1) && (dy == 2) && (dx == 2);
            exp_t.push_back(e);
          end
  endfunction

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({o_in_ready, o_write_pixel_signal, o_read_pixel_signal, o_tap_valid, o_busy, o_done, o_win_last} !== 7'd0) begin
      errors++;
      $display("FAIL %s_ctl got %b exp 0000000", tag,
        {o_in_ready, o_write_pixel_signal, o_read_pixel_signal, o_tap_valid, o_busy, o_done, o_win_last});
    end
    checks++;
    if ({o_write_pixel_addr, o_write_pixel_data, o_read_pixel_addr} !== 48'd0) begin
      errors++;
      $display("FAIL %s_addr got %h exp 0", tag, {o_write_pixel_addr, o_write_pixel_data, o_read_pixel_addr});
    end
    checks++;
    if ({o_tap_data, o_tap_idx} !== 52'd0) begin
      errors++;
      $display("FAIL %s_tap got %h exp 0", tag, {o_tap_data, o_tap_idx});
    end
  endtask

  task automatic test_reset;
    rst = 1; step; step;
    check_reset_outputs("reset");
    rst = 0; step;
    checks++;
    if ({o_busy, o_in_ready} !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset got %b exp 00", {o_busy, o_in_ready});
    end
  endtask

  task automatic test_load(input bit use_index);
    int k = 0, cyc = 0, bad = 0;
    logic acc;
    for (int n = 0; n < 3072; n++) img[n] = use_index ? 16'(n) : 16'($urandom);
    build_exp();
    clear_logs();
    tap_ready = 0;
    start = 1; step; start = 0;
    while (k < 3072 && cyc < 20000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = img[k];
      start    = (k == 1000);  // must be ignored mid-load
      #1;
      acc = in_valid && o_in_ready;
      step;
      if (acc) k++;
      cyc++;
    end
    in_valid = 0; start = 0;
    checks++;
    if (k != 3072) begin errors++; $display("FAIL load_accepts got %0d exp 3072", k); end
    if (wq.size() != 3072) bad++;
    for (int n = 0; n < wq.size() && n < 3072; n++)
      if (wq[n] !== {16'(n), img[n]}) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL load_writes got %0d bad exp 0 (count %0d)", bad, wq.size()); end
    checks++;
    if ({o_busy, o_in_ready} !== 2'b10) begin
      errors++; $display("FAIL post_load got busy,in_ready=%b exp 10", {o_busy, o_in_ready});
    end
  endtask

  task automatic test_first_window;
    int cyc = 0, bad = 0;
    tap_ready = 1;
    start = 1;  // ignored in SWEEP
    while (tq.size() < 9 && cyc < 50) begin step; start = 0; cyc++; end
    tap_ready = 0; start = 0;
    checks++;
    if (tq.size() != 9) begin errors++; $display("FAIL win0_count got %0d exp 9", tq.size()); end
    for (int n = 0; n < 9 && n < tq.size(); n++) if (tq[n] !== exp_t[n]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL win0_taps got %0d bad exp 0 (tap0 %h exp %h)", bad, tq[0], exp_t[0]); end
    bad = 0;
    for (int n = 0; n < rq.size(); n++) if (rq[n] !== exp_r[n]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL win0_reads got %0d bad exp 0 (rd0 %h exp %h)", bad, rq[0], exp_r[0]); end
  endtask

  task automatic test_stall;
    int bad = 0;
    tap_ready = 1; step; step; step; step;
    tap_ready = 0;
    repeat (5) step;
    checks++;
    if (o_tap_valid !== 1'b1) begin errors++; $display("FAIL stall_full got valid %b exp 1", o_tap_valid); end
    tap_ready = 1; step;
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL stall_stable got %0d changes exp 0", stall_bad); end
    checks++;
    if (max_out > 2) begin errors++; $display("FAIL stall_outstanding got %0d exp <=2", max_out); end
    for (int n = 0; n < tq.size(); n++) if (tq[n] !== exp_t[n]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_order got %0d bad exp 0", bad); end
  endtask

  task automatic test_full_sweep;
    int cyc = 0, bad = 0, nlast = 0;
    while (done_cnt == 0 && cyc < 60000) begin
      tap_ready = ($urandom_range(0, 3) != 0);
      step; cyc++;
    end
    tap_ready = 1;
    repeat (3) step;
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL sweep_done got %0d pulses exp 1", done_cnt); end
    checks++;
    if (tq.size() != exp_t.size()) begin errors++; $display("FAIL sweep_taps got %0d exp %0d", tq.size(), exp_t.size()); end
    for (int n = 0; n < tq.size() && n < exp_t.size(); n++) begin
      if (tq[n] !== exp_t[n]) bad++;
      if (tq[n].l) nlast++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL sweep_tap_data got %0d bad exp 0", bad); end
    checks++;
    if (rq.size() != exp_r.size()) begin errors++; $display("FAIL sweep_reads got %0d exp %0d", rq.size(), exp_r.size()); end
    bad = 0;
    for (int n = 0; n < rq.size() && n < exp_r.size(); n++) if (rq[n] !== exp_r[n]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL sweep_read_addr got %0d bad exp 0", bad); end
    checks++;
    if (rq.size() == 0 || rq[rq.size()-1] !== 16'd1023) begin
      errors++; $display("FAIL sweep_last_read got %h exp 03ff", (rq.size() != 0) ? rq[rq.size()-1] : 16'hxxxx);
    end
    checks++;
    if (nlast != 1 || tq.size() == 0 || !tq[tq.size()-1].l) begin
      errors++; $display("FAIL sweep_win_last got %0d flags exp 1 on final tap", nlast);
    end
    checks++;
    if ({o_busy, o_tap_valid, o_in_ready} !== 3'b000) begin
      errors++; $display("FAIL sweep_idle got %b exp 000", {o_busy, o_tap_valid, o_in_ready});
    end
    checks++;
    if (stall_bad != 0 || max_out > 2 || overlap != 0) begin
      errors++; $display("FAIL sweep_stream got stall %0d out %0d overlap %0d exp 0 <=2 0", stall_bad, max_out, overlap);
    end
  endtask

  task automatic test_reset_mid;
    test_load(1'b0);
    tap_ready = 1;
    repeat (300) step;
    rst = 1; step;
    check_reset_outputs("rst_mid");
    rst = 0;
    repeat (4) step;
    checks++;
    if (done_cnt != 0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_nodone got done %0d busy %b exp 0 0", done_cnt, o_busy);
    end
  endtask

  initial begin
    test_reset;
    test_load(1'b1);
    test_first_window;
    test_stall;
    test_full_sweep;
    test_reset_mid;
    test_load(1'b0);
    test_full_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_mem_ctrl.md
# pixel_mem_ctrl

Sequencer for the 32x32x3 pixel local memory, sitting between the input DMA stream and the convolution datapath. It loads one image as a 16-bit word stream into the R, G and B planes of the memory. It then sweeps 3x3 windows in raster order, issuing one 48-bit RGB read per tap. Taps go to the convolution engine through a valid/ready stream with a 2-entry skid buffer. Write and read phases never overlap, so the memory's write and read ports are never active in the same cycle.

## Interface
- DATA_W, 16: width of one colour sample.
- IMG_DIM, 32: image side in pixels. Only 32 is supported, fixed by the 10-bit memory addressing.
- KSIZE, 3: window side. Only 3 is supported.

Ports:
- clk  in  1  clock; the memory is clocked on ~clk.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins LOAD. It is honoured only in IDLE.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller accepts a sample.
- in_data  in  16  input sample. Order is channel-major (R plane, then G, then B), each plane raster order.
- write_pixel_signal  out  1  memory write strobe.
- write_pixel_addr  out  16  {4'b0, channel[1:0], pixel[9:0]}.
- write_pixel_data  out  16  sample to write.
- read_pixel_signal  out  1  memory read enable.
- read_pixel_addr  out  16  {6'b0, pixel[9:0]}.
- read_pixel_data  in  48  {B,G,R} returned from memory.
- tap_valid  out  1  tap available.
- tap_ready  in  1  consumer accepts the tap.
- tap_data  out  48  RGB tap.
- tap_idx  out  4  tap index 0..8, row-major within the window.
- win_last  out  1  qualifies the tap with idx 8 of the final window.
- busy  out  1  high in LOAD and SWEEP.
- done  out  1  single-cycle pulse when the final tap is accepted.

## Operation
- States: IDLE, LOAD, SWEEP, DRAIN.
- IDLE to LOAD on start.
- LOAD:
  - in_ready = 1.
  - Each accepted sample (in_valid & in_ready) writes combinationally in the same cycle: write_pixel_signal = 1, write_pixel_addr = {4'b0, ld_cnt[11:0]}, write_pixel_data = in_data.
  - ld_cnt increments on each accepted sample.
  - After the 3072nd accepted sample, go to SWEEP with ld_cnt cleared.
- SWEEP:
  - Counters oy, ox (0..29) and dy, dx (0..2).
  - Address = (oy+dy)*32 + (ox+dx).
  - A read is issued (read_pixel_signal = 1) only when the buffer will have space after this cycle's pop: count − pop < 2.
  - dx is the fastest-moving counter, then dy, then ox, then oy.
  - After the issue for oy=29, ox=29, dy=2, dx=2, go to DRAIN.
- DRAIN:
  - No further reads.
  - When the buffer empties and the last tap has been accepted: done pulse, return to IDLE.
- Buffer entries carry {data, idx, last}. tap_valid = buffer not empty.
- start in any state other than IDLE is ignored.
- in_ready = 0 outside LOAD.
- Reset mid-operation: all counters are cleared, the buffer is flushed, the FSM returns to IDLE, and no done pulse is produced.

## Timing
- Reset values:
  - in_ready, write_pixel_signal, read_pixel_signal, tap_valid, busy, done, win_last = 0.
  - All addresses, tap_data and tap_idx = 0.
- Write latency: 0. A sample is committed at the memory's falling edge in the accept cycle.
- Read latency:
  - Address issued in cycle N.
  - Memory samples it at the mid-cycle falling edge.
  - Data is captured into the buffer at the rising edge ending cycle N.
  - tap_valid is earliest in cycle N+1.
- Throughput: 1 tap/cycle with tap_ready held high. 8100 taps in total (900 windows × 9).
- The tap stream holds tap_data, tap_idx and win_last stable while tap_valid & !tap_ready.
- LOAD to SWEEP: first read is issued in the cycle after the final write.

## Configuration
- Macro PIXEL_ZERO_PAD_EN.
- Defined:
  - oy and ox range 0..31, giving 1024 windows and 9216 taps.
  - Tap coordinate = (oy+dy−1, ox+dx−1).
  - Out-of-range taps push 48'd0 into the buffer without asserting read_pixel_signal. They use the same space rule as reads.
- Undefined: valid-only sweep over a 30x30 grid, as in Operation.

## Structure
- Package pixel_ctrl_pkg holds:
  - the state enum ctrl_state_e;
  - constants IMG_DIM, KSIZE, PLANE_WORDS=1024, LOAD_WORDS=3072;
  - typedef tap_t {logic [47:0] data; logic [3:0] idx; logic last;}.
- Sub-module tap_skid_fifo: a 2-entry FIFO of tap_t with count output, push/pop, synchronous flush on rst.

## Test plan
- Load 3072 samples with in_data = index → writes at addr 0x000..0x3FF (R), 0x400..0x7FF (G), 0x800..0xBFF (B), with data matching; afterwards busy = 1, in_ready = 0.
- First window with tap_ready = 1 → read addrs 0, 1, 2, 32, 33, 34, 64, 65, 66; tap_idx 0..8; tap_data = {0x800+addr, 0x400+addr, addr}.
- tap_ready low for 5 cycles mid-window → at most 2 reads outstanding, no tap lost or duplicated, tap_data stable.
- Full sweep → 8100 taps; last read addr 1023; win_last only on the final tap; done pulses exactly once; returns to IDLE.
- rst asserted during SWEEP → next cycle all outputs at reset values; a new start reloads cleanly.
- With PIXEL_ZERO_PAD_EN → first window taps 0, 1, 2 and 3 equal 0 with no read issued; tap 4 reads addr 0; 9216 taps in total.
